// File: rtl/stage_3_exec_pkg.sv
// Shared pipeline package: data/register typedefs, the ALU opcode set and the
// single-cycle ALU function. Multiply/divide support is compiled in by RV_M_EXT_EN.
package stage_3_exec_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0]      reg_id_t;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

    // Registered bundle handed to the memory stage.
    typedef struct packed {
        logic    valid;
        data_t   alu_res;
        data_t   rs2_val;
        reg_id_t rd_idx;
        logic    mem_load;
        logic    mem_store;
        logic    reg_write;
    } exec_out_t;

`ifdef RV_M_EXT_EN
    typedef enum logic {
        ST_IDLE,
        ST_DIV_BUSY
    } exec_state_e;

    function automatic logic is_div_op(alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_rem_op(alu_op_e op);
        return op inside {ALU_REM, ALU_REMU};
    endfunction
`endif

    // Everything except the iterative divide. Division opcodes fall to the
    // default arm; their result comes from the divider instead.
    function automatic data_t alu_compute(alu_op_e op, data_t a, data_t b);
        logic [4:0] shamt;
        data_t      res;
`ifdef RV_M_EXT_EN
        logic [2*XLEN-1:0] a_ext;
        logic [2*XLEN-1:0] b_ext;
        logic [2*XLEN-1:0] prod;
        // One 64-bit multiplier: the low 64 bits of the product of the
        // extended operands are exact for every signedness combination.
        a_ext = (op inside {ALU_MULH, ALU_MULHSU}) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        b_ext = (op == ALU_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        prod  = a_ext * b_ext;
`endif
        shamt = b[4:0];
        case (op)
            ALU_ADD:    res = a + b;
            ALU_SUB:    res = a - b;
            ALU_SLL:    res = a << shamt;
            ALU_SLT:    res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   res = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:    res = a ^ b;
            ALU_SRL:    res = a >> shamt;
            ALU_SRA:    res = $signed(a) >>> shamt;
            ALU_OR:     res = a | b;
            ALU_AND:    res = a & b;
`ifdef RV_M_EXT_EN
            ALU_MUL:    res = prod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  res = prod[2*XLEN-1:XLEN];
`endif
            default:    res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/stage_3_exec_if.sv
// Decode-to-execute bundle plus the registered execute-to-memory bundle.
// master = upstream/downstream side, slave = the execute stage.
interface stage_3_exec_if;
    import stage_3_exec_pkg::*;

    logic    stall;
    logic    in_valid;
    data_t   rs1_val;
    data_t   rs2_val;
    data_t   imm;
    logic    use_imm;
    alu_op_e alu_op;
    reg_id_t rd_idx;
    logic    mem_load_enable;
    logic    mem_store_enable;
    logic    reg_write_enable;

    logic    busy_out;
    logic    valid_out;
    data_t   alu_res_out;
    data_t   rs2_val_out;
    reg_id_t rd_idx_out;
    logic    mem_load_out;
    logic    mem_store_out;
    logic    reg_write_out;

    modport master (
        output stall, in_valid, rs1_val, rs2_val, imm, use_imm, alu_op, rd_idx,
               mem_load_enable, mem_store_enable, reg_write_enable,
        input  busy_out, valid_out, alu_res_out, rs2_val_out, rd_idx_out,
               mem_load_out, mem_store_out, reg_write_out
    );

    modport slave (
        input  stall, in_valid, rs1_val, rs2_val, imm, use_imm, alu_op, rd_idx,
               mem_load_enable, mem_store_enable, reg_write_enable,
        output busy_out, valid_out, alu_res_out, rs2_val_out, rd_idx_out,
               mem_load_out, mem_store_out, reg_write_out
    );

endinterface

// File: rtl/stage_3_exec_seq_divider.sv
// Restoring divider, one quotient bit per cycle for 32 cycles. Signed ops run on
// magnitudes with a sign fix-up; quotient/remainder are valid in the cycle done=1.
module seq_divider
    import stage_3_exec_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  start,
    input  logic  signed_op,
    input  data_t dividend,
    input  data_t divisor,
    output logic  busy,
    output logic  done,
    output data_t quotient,
    output data_t remainder
);

    logic [4:0]  count;
    data_t       rem_q;
    data_t       quo_q;
    data_t       dvsr_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        neg_a;
    logic        neg_b;
    data_t       mag_a;
    data_t       mag_b;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    data_t       rem_nxt;
    data_t       quo_nxt;
    logic        load;
    logic        step;

    assign load = start & ~busy & ~hold;
    assign step = busy & ~hold;
    assign done = step & (count == 5'd31);

    always_comb begin
        neg_a   = signed_op & dividend[XLEN-1];
        neg_b   = signed_op & divisor[XLEN-1];
        mag_a   = neg_a ? -dividend : dividend;
        mag_b   = neg_b ? -divisor : divisor;
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_q};
        if (diff[XLEN]) begin
            rem_nxt = shifted[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    assign quotient  = neg_quo_q ? -quo_nxt : quo_nxt;
    assign remainder = neg_rem_q ? -rem_nxt : rem_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= 5'd0;
        end else if (load) begin
            busy  <= 1'b1;
            count <= 5'd0;
        end else if (step) begin
            count <= count + 5'd1;
            if (count == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

    // NOTE: the datapath registers carry no reset; they are always loaded at
    // start before being read, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q     <= '0;
            quo_q     <= mag_a;
            dvsr_q    <= mag_b;
            // Divide-by-zero yields all-ones regardless of operand signs.
            neg_quo_q <= (neg_a ^ neg_b) & (divisor != '0);
            neg_rem_q <= neg_a;
        end else if (step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/stage_3_exec.sv
// Execute stage: single-cycle ALU/multiply, iterative divide held in DIV_BUSY.
// Multiply/divide support is compiled only when RV_M_EXT_EN is defined.
module stage_3_exec #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    stage_3_exec_if.slave bus
);
    import stage_3_exec_pkg::*;

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    exec_out_t       issue_b;
    exec_out_t       out_q;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        op_b    = bus.use_imm ? bus.imm : bus.rs2_val;
        alu_res = alu_compute(bus.alu_op, bus.rs1_val, op_b);
        issue_b = '{
            valid:     bus.in_valid,
            alu_res:   alu_res,
            rs2_val:   bus.rs2_val,
            rd_idx:    bus.rd_idx,
            mem_load:  bus.in_valid & bus.mem_load_enable,
            mem_store: bus.in_valid & bus.mem_store_enable,
            reg_write: bus.in_valid & bus.reg_write_enable
        };
    end

`ifdef RV_M_EXT_EN
    exec_state_e state;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    data_t       div_quo;
    data_t       div_rem;
    exec_out_t   div_b;

    // Pass-through fields captured at divide start, replayed with the result.
    logic        held_is_rem;
    data_t       held_rs2;
    reg_id_t     held_rd;
    logic        held_ld;
    logic        held_st;
    logic        held_wr;

    assign div_start = (state == ST_IDLE) & bus.in_valid & ~bus.stall
                       & is_div_op(bus.alu_op) & ~div_busy;

    seq_divider u_seq_divider (
        .clk       (clk),
        .rst       (rst),
        .hold      (bus.stall),
        .start     (div_start),
        .signed_op (bus.alu_op inside {ALU_DIV, ALU_REM}),
        .dividend  (bus.rs1_val),
        .divisor   (op_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (div_start) begin
            held_is_rem <= is_rem_op(bus.alu_op);
            held_rs2    <= bus.rs2_val;
            held_rd     <= bus.rd_idx;
            held_ld     <= bus.mem_load_enable;
            held_st     <= bus.mem_store_enable;
            held_wr     <= bus.reg_write_enable;
        end
    end

    always_comb begin
        div_b = '{
            valid:     1'b1,
            alu_res:   held_is_rem ? div_rem : div_quo,
            rs2_val:   held_rs2,
            rd_idx:    held_rd,
            mem_load:  held_ld,
            mem_store: held_st,
            reg_write: held_wr
        };
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            out_q <= '0;
        end else if (!bus.stall) begin
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        state <= ST_DIV_BUSY;
                        out_q <= '0;
                    end else begin
                        out_q <= issue_b;
                    end
                end
                ST_DIV_BUSY: begin
                    if (div_done) begin
                        state <= ST_IDLE;
                        out_q <= div_b;
                    end else begin
                        out_q <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    out_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy_out = (state == ST_DIV_BUSY);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (!bus.stall) begin
            out_q <= issue_b;
        end
    end

    assign bus.busy_out = 1'b0;
`endif

    assign bus.valid_out     = out_q.valid;
    assign bus.alu_res_out   = out_q.alu_res;
    assign bus.rs2_val_out   = out_q.rs2_val;
    assign bus.rd_idx_out    = out_q.rd_idx;
    assign bus.mem_load_out  = out_q.mem_load;
    assign bus.mem_store_out = out_q.mem_store;
    assign bus.reg_write_out = out_q.reg_write;

endmodule

// File: tb/tb_stage_3_exec.sv
// Scoreboard bench for stage_3_exec: the driver queues expected bundles, a
// negedge monitor pops and compares whenever valid_out is presented unstalled.
module tb_stage_3_exec;
    import stage_3_exec_pkg::*;

`ifdef RV_M_EXT_EN
    localparam bit M_EXT = 1'b1;
`else
    localparam bit M_EXT = 1'b0;
`endif

    typedef struct {
        data_t      res;
        data_t      rs2;
        reg_id_t    rd;
        logic [2:0] ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    stage_3_exec_if bus ();

    stage_3_exec #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // M-extension result when compiled in, otherwise the ADD the stage falls back to.
    function automatic data_t pick(input data_t m_res, input data_t a, input data_t b);
        return M_EXT ? m_res : a + b;
    endfunction

    function automatic int div_lat(input int cycles);
        return M_EXT ? cycles : 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !bus.stall && bus.valid_out) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got result 0x%08h, expected no output", bus.alu_res_out);
            end else begin
                e = exp_q.pop_front();
                check("alu_res_out", bus.alu_res_out, e.res);
                check("rs2_val_out", bus.rs2_val_out, e.rs2);
                check("rd_idx_out", 32'(bus.rd_idx_out), 32'(e.rd));
                check("ctl_out", 32'({bus.mem_load_out, bus.mem_store_out, bus.reg_write_out}), 32'(e.ctl));
            end
        end
    end

    task automatic drive(input alu_op_e op, input data_t a, input data_t rs2, input logic ui,
                         input data_t imm_v, input reg_id_t rd, input logic [2:0] ctl);
        bus.alu_op           = op;
        bus.rs1_val          = a;
        bus.rs2_val          = rs2;
        bus.use_imm          = ui;
        bus.imm              = imm_v;
        bus.rd_idx           = rd;
        bus.mem_load_enable  = ctl[2];
        bus.mem_store_enable = ctl[1];
        bus.reg_write_enable = ctl[0];
        bus.in_valid         = 1'b1;
    endtask

    // Issue one op, count busy cycles (optionally stalling mid-way), then
    // confirm the result is presented the cycle busy drops.
    task automatic issue(input string name, input alu_op_e op, input data_t a, input data_t rs2,
                         input logic ui, input data_t imm_v, input reg_id_t rd, input logic [2:0] ctl,
                         input data_t exp_res, input int exp_busy, input int stall_at, input int stall_len);
        int n;
        exp_q.push_back('{exp_res, rs2, rd, ctl});
        drive(op, a, rs2, ui, imm_v, rd, ctl);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.busy_out && n < 200) begin
            n++;
            if (n == stall_at) bus.stall = 1'b1;
            if (n == stall_at + stall_len) bus.stall = 1'b0;
            @(posedge clk); #1;
        end
        bus.stall = 1'b0;
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        check({name, "_valid_out"}, 32'(bus.valid_out), 32'd1);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_valid_out"}, 32'(bus.valid_out), 32'd0);
        check({name, "_ctl_out"}, 32'({bus.mem_load_out, bus.mem_store_out, bus.reg_write_out}), 32'd0);
        check({name, "_busy_out"}, 32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        data_t held_res;

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.in_valid = 1'b0;
        bus.alu_op = ALU_ADD;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.imm = '0;
        bus.use_imm = 1'b0;
        bus.rd_idx = '0;
        bus.mem_load_enable = 1'b0;
        bus.mem_store_enable = 1'b0;
        bus.reg_write_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        check("reset_alu_res", bus.alu_res_out, 32'h0);
        check("reset_rd_idx", 32'(bus.rd_idx_out), 32'h0);
        rst = 1'b0;

        // Single-cycle ALU ops
        issue("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 5'd1, 3'b001, 32'h8000_0000, 0, 0, 0);
        @(posedge clk); #1;
        check_cleared("idle_bubble");
        issue("sub_imm", ALU_SUB, 32'h5, 32'h1234, 1'b1, 32'h7, 5'd2, 3'b001, 32'hFFFF_FFFE, 0, 0, 0);
        issue("sll_mask", ALU_SLL, 32'h1, 32'h0, 1'b1, 32'h21, 5'd3, 3'b001, 32'h2, 0, 0, 0);
        issue("srl", ALU_SRL, 32'h8000_0000, 32'h4, 1'b0, 32'h0, 5'd4, 3'b001, 32'h0800_0000, 0, 0, 0);
        issue("sra_mask", ALU_SRA, 32'h8000_0000, 32'h24, 1'b0, 32'h0, 5'd5, 3'b001, 32'hF800_0000, 0, 0, 0);
        issue("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 5'd6, 3'b001, 32'h1, 0, 0, 0);
        issue("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 5'd7, 3'b001, 32'h0, 0, 0, 0);
        issue("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0, 5'd8, 3'b001, 32'h0FF0_0FF0, 0, 0, 0);
        issue("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0, 5'd9, 3'b001, 32'hFFF0_FFF0, 0, 0, 0);
        issue("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0, 5'd10, 3'b001, 32'hF000_F000, 0, 0, 0);
        issue("load_addr", ALU_ADD, 32'h1000, 32'h0, 1'b1, 32'h10, 5'd11, 3'b101, 32'h1010, 0, 0, 0);
        issue("store_addr", ALU_ADD, 32'h2000, 32'hDEAD_BEEF, 1'b1, 32'h4, 5'd0, 3'b010, 32'h2004, 0, 0, 0);

        // Stall while a result is presented: outputs hold, next op waits
        issue("pre_stall", ALU_ADD, 32'h100, 32'h23, 1'b0, 32'h0, 5'd12, 3'b001, 32'h123, 0, 0, 0);
        bus.stall = 1'b1;
        drive(ALU_SUB, 32'h50, 32'h8, 1'b0, 32'h0, 5'd13, 3'b001);
        repeat (2) begin
            @(posedge clk); #1;
        end
        held_res = bus.alu_res_out;
        check("stall_hold_valid", 32'(bus.valid_out), 32'd1);
        check("stall_hold_res", held_res, 32'h123);
        exp_q.push_back('{32'h48, 32'h8, 5'd13, 3'b001});
        bus.stall = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("post_stall_valid", 32'(bus.valid_out), 32'd1);

        // Multiply
        issue("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd14, 3'b001,
              pick(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0, 0, 0);
        issue("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd15, 3'b001,
              pick(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0, 0, 0);
        issue("mul", ALU_MUL, 32'h3, 32'hFFFF_FFFE, 1'b0, 32'h0, 5'd16, 3'b001,
              pick(32'hFFFF_FFFA, 32'h3, 32'hFFFF_FFFE), 0, 0, 0);
        issue("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'h0, 5'd17, 3'b001,
              pick(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2), 0, 0, 0);

        // Divide, including divide-by-zero and signed overflow
        issue("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'h0, 5'd18, 3'b101,
              pick(32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h2), div_lat(32), 0, 0);
        issue("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'h0, 5'd19, 3'b001,
              pick(32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h2), div_lat(32), 0, 0);
        issue("divu_zero", ALU_DIVU, 32'h5, 32'h0, 1'b0, 32'h0, 5'd20, 3'b001,
              pick(32'hFFFF_FFFF, 32'h5, 32'h0), div_lat(32), 0, 0);
        issue("remu_zero", ALU_REMU, 32'h5, 32'h0, 1'b0, 32'h0, 5'd21, 3'b001,
              pick(32'h5, 32'h5, 32'h0), div_lat(32), 0, 0);
        issue("div_zero_neg", ALU_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'h0, 5'd22, 3'b001,
              pick(32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0), div_lat(32), 0, 0);
        issue("rem_zero_neg", ALU_REM, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'h0, 5'd23, 3'b001,
              pick(32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0), div_lat(32), 0, 0);
        issue("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd24, 3'b001,
              pick(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF), div_lat(32), 0, 0);
        issue("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd25, 3'b001,
              pick(32'h0, 32'h8000_0000, 32'hFFFF_FFFF), div_lat(32), 0, 0);
        issue("divu_imm_stall", ALU_DIVU, 32'd100, 32'hCAFE_0000, 1'b1, 32'd7, 5'd26, 3'b011,
              pick(32'd14, 32'd100, 32'd7), div_lat(36), 10, 4);

        // Reset partway through a division: nothing must come out
        if (!M_EXT) exp_q.push_back('{32'h0000_0009, 32'h2, 5'd27, 3'b001});
        drive(ALU_DIVU, 32'h7, 32'h2, 1'b0, 32'h0, 5'd27, 3'b001);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", 32'(bus.busy_out), 32'(M_EXT));
        rst = 1'b1;
        @(posedge clk); #1;
        check_cleared("mid_div_reset");
        check("mid_div_reset_res", bus.alu_res_out, 32'h0);
        check("mid_div_reset_rs2", bus.rs2_val_out, 32'h0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_cleared("after_reset_quiet");

        issue("post_reset_add", ALU_ADD, 32'h11, 32'h22, 1'b0, 32'h0, 5'd28, 3'b001, 32'h33, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
